// File: rtl/btn_debounce_multi.sv
// N-channel button/switch debouncer: per-channel synchroniser, STABLE/PENDING filter, level output plus rise/fall strobes.
// Optional sticky per-channel interrupt flags when BTN_DEBOUNCE_IRQ_EN is defined.
module btn_debounce_multi #(
    parameter int   N_CH            = 4,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 10000,
    parameter logic RST_LEVEL       = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] q_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic            changed_o
`ifdef BTN_DEBOUNCE_IRQ_EN
    ,
    input  logic [N_CH-1:0] irq_clr_i,
    output logic [N_CH-1:0] irq_o
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s;
            state_t                 state_reg, state_next;
            logic [CNT_W-1:0]       cnt_reg, cnt_next;
            logic                   q_reg, q_next;
            logic                   rise_reg, rise_next;
            logic                   fall_reg, fall_next;
            logic                   accept;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync_reg <= {SYNC_STAGES{RST_LEVEL}};
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_i[gi]};
                end
            end

            assign s = sync_reg[SYNC_STAGES-1];

            // The DEBOUNCE_CYCLES-th consecutive differing sample commits the new level.
            assign accept = (state_reg == ST_PENDING) && (s != q_reg) && (cnt_reg == CNT_MAX);

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_reg <= ST_STABLE;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    ST_STABLE: begin
                        if (s != q_reg) begin
                            state_next = ST_PENDING;
                            cnt_next   = CNT_W'(1);
                        end else begin
                            cnt_next   = '0;
                        end
                    end
                    ST_PENDING: begin
                        if (s == q_reg || cnt_reg == CNT_MAX) begin
                            state_next = ST_STABLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next   = cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next = ST_STABLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            always_comb begin
                q_next    = q_reg;
                rise_next = 1'b0;
                fall_next = 1'b0;
                if (accept) begin
                    q_next    = s;
                    rise_next = s;
                    fall_next = ~s;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    q_reg    <= RST_LEVEL;
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else begin
                    q_reg    <= q_next;
                    rise_reg <= rise_next;
                    fall_reg <= fall_next;
                end
            end

            assign q_o[gi]    = q_reg;
            assign rise_o[gi] = rise_reg;
            assign fall_o[gi] = fall_reg;

`ifdef BTN_DEBOUNCE_IRQ_EN
            logic irq_reg;

            // Set has priority over a clear arriving in the same cycle.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    irq_reg <= 1'b0;
                end else if (rise_reg | fall_reg) begin
                    irq_reg <= 1'b1;
                end else if (irq_clr_i[gi]) begin
                    irq_reg <= 1'b0;
                end
            end

            assign irq_o[gi] = irq_reg;
`endif
        end
    endgenerate

    assign changed_o = |(rise_o | fall_o);

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Scoreboard bench for btn_debounce_multi: window-based reference model queues expected strobe events, monitor compares.
module tb_btn_debounce_multi;
    localparam int N  = 4;
    localparam int SS = 2;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] q_o, rise_o, fall_o;
    logic         changed_o;
`ifdef BTN_DEBOUNCE_IRQ_EN
    logic [N-1:0] irq_clr = '0;
    logic [N-1:0] irq_o;
`endif

    btn_debounce_multi #(
        .N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .RST_LEVEL(1'b0)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .btn_i(btn),
        .q_o(q_o),
        .rise_o(rise_o),
        .fall_o(fall_o),
        .changed_o(changed_o)
`ifdef BTN_DEBOUNCE_IRQ_EN
        ,
        .irq_clr_i(irq_clr),
        .irq_o(irq_o)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int           cyc;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] q;
    } ev_t;
    ev_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: raw input delayed SS edges, level accepted once the last DC samples all differ from it.
    int           edge_cnt = 0;
    logic [N-1:0] pipe [SS];
    logic [N-1:0] win  [DC];
    logic [N-1:0] mq   = '0;
    logic [N-1:0] mstr = '0;
    logic [N-1:0] mirq = '0;

    always @(posedge clk) begin
        logic [N-1:0] s, r, f;
        logic diff;
        edge_cnt++;
        r = '0;
        f = '0;
        mirq = rst ? '0 : ((mirq & ~irq_clr_val()) | mstr);
        if (rst) begin
            for (int i = 0; i < SS; i++) pipe[i] = '0;
            for (int k = 0; k < DC; k++) win[k] = '0;
            mq = '0;
        end else begin
            s = pipe[SS-1];
            for (int k = DC - 1; k > 0; k--) win[k] = win[k-1];
            win[0] = s;
            for (int i = SS - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = btn;
            for (int ch = 0; ch < N; ch++) begin
                diff = 1'b1;
                for (int k = 0; k < DC; k++)
                    if (win[k][ch] == mq[ch]) diff = 1'b0;
                if (diff) begin
                    if (s[ch]) r[ch] = 1'b1;
                    else       f[ch] = 1'b1;
                    mq[ch] = s[ch];
                end
            end
            if ((r | f) != '0) exp_q.push_back('{edge_cnt, r, f, mq});
        end
        mstr = r | f;
    end

    function automatic logic [N-1:0] irq_clr_val();
`ifdef BTN_DEBOUNCE_IRQ_EN
        return irq_clr;
`else
        return '0;
`endif
    endfunction

    // Monitor: a strobe cycle (changed_o) pops the scoreboard; quiet cycles must show no strobes.
    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            logic hit;
            ev_t  e;
            hit = (exp_q.size() > 0) && (exp_q[0].cyc == edge_cnt);
            if (hit) begin
                e = exp_q.pop_front();
                $display("event cyc=%0d rise=%b fall=%b q=%b changed=%b", edge_cnt, rise_o, fall_o, q_o, changed_o);
                chk("ev_changed", 32'(changed_o), 32'd1);
                chk("ev_rise", 32'(rise_o), 32'(e.rise));
                chk("ev_fall", 32'(fall_o), 32'(e.fall));
                chk("ev_q", 32'(q_o), 32'(e.q));
            end else if (changed_o) begin
                $display("event cyc=%0d rise=%b fall=%b q=%b (unexpected)", edge_cnt, rise_o, fall_o, q_o);
                chk("extra_strobe", 32'(changed_o), 32'd0);
            end else begin
                chk("idle_strobes", 32'({rise_o, fall_o}), 32'd0);
            end
            chk("q_level", 32'(q_o), 32'(mq));
`ifdef BTN_DEBOUNCE_IRQ_EN
            chk("irq", 32'(irq_o), 32'(mirq));
`endif
        end
    end

    initial begin
        int hold [N];
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_q", 32'(q_o), 32'd0);
        chk("reset_strobes", 32'({rise_o, fall_o, changed_o}), 32'd0);
        repeat (3) @(negedge clk);

        // Clean press on ch0: new level visible after the 6th edge.
        btn = 4'b0001;
        repeat (5) @(negedge clk);
        chk("press_early_q", 32'(q_o), 32'd0);
        @(negedge clk);
        chk("press_q", 32'(q_o), 32'b0001);
        chk("press_rise", 32'(rise_o), 32'b0001);
        chk("press_changed", 32'(changed_o), 32'd1);
        @(negedge clk);
        chk("press_rise_one_cycle", 32'(rise_o), 32'd0);
        repeat (4) @(negedge clk);

        // Bounce on ch1 never reaches DC consecutive samples.
        for (int r = 0; r < 5; r++) begin
            btn[1] = 1'b1;
            repeat (3) @(negedge clk);
            btn[1] = 1'b0;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        chk("bounce_q", 32'(q_o), 32'b0001);

        // Release on ch0.
        btn[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("release_early_q", 32'(q_o), 32'b0001);
        @(negedge clk);
        chk("release_q", 32'(q_o), 32'd0);
        chk("release_fall", 32'(fall_o), 32'b0001);
        chk("release_rise", 32'(rise_o), 32'd0);
        repeat (4) @(negedge clk);

        // Simultaneous rise on ch1 and ch3.
        btn = 4'b1010;
        repeat (6) @(negedge clk);
        chk("simul_q", 32'(q_o), 32'b1010);
        chk("simul_rise", 32'(rise_o), 32'b1010);
        @(negedge clk);
        chk("simul_changed_one_cycle", 32'(changed_o), 32'd0);
        btn = 4'b0000;
        repeat (10) @(negedge clk);

        // Reset in the middle of a pending transition on ch2.
        btn = 4'b0100;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_q", 32'(q_o), 32'd0);
        repeat (5) @(negedge clk);
        chk("midrst_early_q", 32'(q_o), 32'd0);
        @(negedge clk);
        chk("midrst_q_after", 32'(q_o), 32'b0100);
        chk("midrst_rise", 32'(rise_o), 32'b0100);
        repeat (4) @(negedge clk);

        // Randomised hold lengths around DC, occasional resets and interrupt clears.
        for (int ch = 0; ch < N; ch++) hold[ch] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (hold[ch] == 0) begin
                    btn[ch]  = $urandom_range(0, 1);
                    hold[ch] = $urandom_range(1, 8);
                end else begin
                    hold[ch]--;
                end
            end
            rst = ($urandom_range(0, 199) == 0);
`ifdef BTN_DEBOUNCE_IRQ_EN
            for (int ch = 0; ch < N; ch++) irq_clr[ch] = ($urandom_range(0, 3) == 0);
`endif
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
